noc_output_arbiter: RTL and testbench

- Round-robin arbiter for one router output port, shared among NUM_REQ input ports (N, E, S, W, Local by default).
- Grants one requester, holds the grant for the whole packet, and releases it on the tail flit.
- A slice timer forces release of long or stalled packets. It uses up-counter-with-load semantics: load a start value, count up, expire at all-ones.
- Sits between the input-buffer request logic and the output-port mux/crossbar select.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_output_arbiter_if.sv | 26 ++
 rtl/noc_output_arbiter_rr_pick.sv | 25 ++
 rtl/noc_output_arbiter.sv | 113 +++++++++++
 tb/tb_noc_output_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants: port indices and output-arbiter state encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef logic state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Request/grant bundle between input-buffer request logic and one output-port arbiter.
interface noc_output_arbiter_if #(
    parameter int NUM_REQ = noc_pkg::NUM_PORTS,
    parameter int SLICE_W = 6,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] tail;
    logic               out_ready;
    logic [SLICE_W-1:0] slice_init;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               fire;
    logic               busy;
    logic               expire;

    modport master (
        output req, tail, out_ready, slice_init,
        input  grant, grant_id, fire, busy, expire
    );

    modport slave (
        input  req, tail, out_ready, slice_init,
        output grant, grant_id, fire, busy, expire
    );
endinterface

// File: rtl/noc_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    sel,
    output logic               any_req
);
    int idx;

    // Walk the scan order backwards so the last hit is the nearest one after ptr.
    always_comb begin
        sel     = '0;
        idx     = 0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                sel = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin output-port arbiter: holds a grant for a whole packet, with a slice timer forcing release.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS,
    parameter int SLICE_W = 6,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst,
    noc_output_arbiter_if.slave arb
);
    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [ID_W-1:0]    grant_id_reg, grant_id_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [SLICE_W-1:0] timer_reg, timer_next;
    logic               expire_reg, expire_next;

    logic [ID_W-1:0]    sel;
    logic               any_req;
    logic               req_g, tail_g, fire, timer_max;
    logic               release_tail, release_force;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (arb.req),
        .ptr     (ptr_reg),
        .sel     (sel),
        .any_req (any_req)
    );

    // grant_reg is one-hot in GRANT and zero in IDLE, so masking picks out the owner's bits.
    assign req_g         = |(grant_reg & arb.req);
    assign tail_g        = |(grant_reg & arb.tail);
    assign fire          = req_g & arb.out_ready;
    assign timer_max     = &timer_reg;
    assign release_tail  = fire & tail_g;
    assign release_force = fire & ~tail_g & timer_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) state_next = ST_GRANT;
            end
            default: begin
                if (!req_g || release_tail || release_force) state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        ptr_next      = ptr_reg;
        timer_next    = timer_reg;
        expire_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next    = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                    grant_id_next = sel;
                    ptr_next      = sel;
                    timer_next    = arb.slice_init;
                end
            end
            default: begin
                // A tail always wins over expiry; stalls leave the slice untouched.
                if (!req_g || release_tail) begin
                    grant_next = '0;
                end else if (release_force) begin
                    grant_next  = '0;
                    expire_next = 1'b1;
                end else if (fire) begin
                    timer_next = timer_reg + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_reg    <= '0;
            grant_id_reg <= '0;
            ptr_reg      <= ID_W'(NUM_REQ - 1);
            timer_reg    <= '0;
            expire_reg   <= 1'b0;
        end else begin
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            ptr_reg      <= ptr_next;
            timer_reg    <= timer_next;
            expire_reg   <= expire_next;
        end
    end

    assign arb.grant    = grant_reg;
    assign arb.grant_id = grant_id_reg;
    assign arb.fire     = fire;
    assign arb.busy     = (state_reg == ST_GRANT);
    assign arb.expire   = expire_reg;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter; grant order is checked through an expected-grant scoreboard.
module tb_noc_output_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   exp_q[$];
    logic [4:0] prev_grant;
    int   fires;

    noc_output_arbiter_if arb_if ();

    noc_output_arbiter dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every fresh grant must match the next expected requester.
    always @(negedge clk) begin
        if (rst && arb_if.grant != 5'd0 && prev_grant == 5'd0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL sb_unexpected: observed grant=%0h expected none", arb_if.grant);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("sb_grant_id", 32'(arb_if.grant_id), 32'(e));
                check("sb_grant_onehot", 32'(arb_if.grant), 32'(1) << e);
                $display("txn t=%0t grant=%b grant_id=%0d expected_id=%0d", $time, arb_if.grant, arb_if.grant_id, e);
            end
        end
        prev_grant <= rst ? arb_if.grant : 5'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        arb_if.req       = '0;
        arb_if.tail      = '0;
        arb_if.out_ready = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(arb_if.grant), 32'(0));
        check("rst_grant_id", 32'(arb_if.grant_id), 32'(0));
        check("rst_busy", 32'(arb_if.busy), 32'(0));
        check("rst_expire", 32'(arb_if.expire), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_cmp             = 0;
        n_fail            = 0;
        fires             = 0;
        prev_grant        = '0;
        arb_if.slice_init = '0;

        // Single-flit packet from requester 0.
        do_reset();
        arb_if.req = 5'b00001; arb_if.tail = 5'b00001; arb_if.out_ready = 1'b1;
        exp_q.push_back(0);
        tick();
        @(negedge clk);
        check("t1_grant", 32'(arb_if.grant), 32'h01);
        check("t1_fire", 32'(arb_if.fire), 32'(1));
        check("t1_busy", 32'(arb_if.busy), 32'(1));
        tick();
        arb_if.req = '0;
        @(negedge clk);
        check("t1_release_grant", 32'(arb_if.grant), 32'(0));
        check("t1_release_busy", 32'(arb_if.busy), 32'(0));
        check("t1_release_expire", 32'(arb_if.expire), 32'(0));

        // All requesting, all tails: rotation 0..4,0 with an idle bubble between grants.
        do_reset();
        arb_if.req = 5'b11111; arb_if.tail = 5'b11111; arb_if.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(k % 5);
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            check("t2_busy", 32'(arb_if.busy), 32'(1));
            tick();
            @(negedge clk);
            check("t2_bubble", 32'(arb_if.grant), 32'(0));
        end
        arb_if.req = '0;

        // Slice expiry after 4 transfers from 60, then requester 0 takes over.
        do_reset();
        arb_if.slice_init = 6'd60;
        arb_if.req = 5'b00100; arb_if.tail = '0; arb_if.out_ready = 1'b1;
        exp_q.push_back(2);
        tick();
        arb_if.req = 5'b00101;
        exp_q.push_back(0);
        @(negedge clk);
        check("t3_expire_e1", 32'(arb_if.expire), 32'(0));
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            if (k <= 4) begin
                check("t3_expire_early", 32'(arb_if.expire), 32'(0));
                check("t3_busy", 32'(arb_if.busy), 32'(1));
            end else begin
                check("t3_expire_pulse", 32'(arb_if.expire), 32'(1));
                check("t3_grant_released", 32'(arb_if.grant), 32'(0));
            end
        end
        tick();
        @(negedge clk);
        check("t3_expire_cleared", 32'(arb_if.expire), 32'(0));
        check("t3_next_grant", 32'(arb_if.grant), 32'h01);
        arb_if.req = '0;
        tick();

        // Expiry with out_ready toggling; slice_init change mid-grant must be ignored.
        do_reset();
        arb_if.slice_init = 6'd60;
        arb_if.req = 5'b00100; arb_if.tail = '0; arb_if.out_ready = 1'b1;
        exp_q.push_back(2);
        fires = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            arb_if.out_ready = (k % 2 == 1);
            if (k == 2) arb_if.slice_init = 6'd0;
            @(negedge clk);
            if (arb_if.fire) fires++;
            if (k <= 7) begin
                check("t4_expire_early", 32'(arb_if.expire), 32'(0));
                check("t4_busy", 32'(arb_if.busy), 32'(1));
            end else begin
                check("t4_expire_pulse", 32'(arb_if.expire), 32'(1));
                check("t4_busy_released", 32'(arb_if.busy), 32'(0));
            end
        end
        check("t4_fire_count", 32'(fires), 32'(4));
        arb_if.req = '0;
        tick();
        @(negedge clk);
        check("t4_expire_cleared", 32'(arb_if.expire), 32'(0));

        // Requester 3 aborts; then 1 beats 3 because ptr=3.
        do_reset();
        arb_if.slice_init = 6'd0;
        arb_if.req = 5'b01000; arb_if.tail = '0; arb_if.out_ready = 1'b1;
        exp_q.push_back(3);
        tick();
        tick();
        arb_if.req = '0;
        tick();
        @(negedge clk);
        check("t5_abort_grant", 32'(arb_if.grant), 32'(0));
        check("t5_abort_busy", 32'(arb_if.busy), 32'(0));
        check("t5_abort_expire", 32'(arb_if.expire), 32'(0));
        arb_if.req = 5'b01010; arb_if.tail = 5'b00010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        @(negedge clk);
        check("t5_grant1", 32'(arb_if.grant), 32'h02);
        tick();
        tick();
        @(negedge clk);
        check("t5_grant3", 32'(arb_if.grant), 32'h08);
        arb_if.req = '0;
        tick();

        // Async reset mid-packet, then requester 0 wins.
        arb_if.req = 5'b00100; arb_if.tail = '0; arb_if.out_ready = 1'b1;
        exp_q.push_back(2);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_grant", 32'(arb_if.grant), 32'(0));
        check("t6_rst_busy", 32'(arb_if.busy), 32'(0));
        arb_if.req = 5'b11111; arb_if.tail = 5'b11111;
        exp_q.push_back(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_grant0", 32'(arb_if.grant), 32'h01);
        tick();
        arb_if.req = '0;
        @(negedge clk);
        check("t6_release", 32'(arb_if.grant), 32'(0));
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
